// File: rtl/mem_bus_pkg.sv
// Shared definitions for the shared-bus memory controller: state encoding
// and the value an undriven data bus reads as.
package mem_bus_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3,
        ST_TURN  = 3'd4
    } state_t;

    // One bit of a released bus; replicate to the bus width where needed.
    localparam logic BUS_IDLE_BIT = 1'bz;

    // True in the states that own the memory's control lines.
    function automatic logic is_mem_access(input state_t s);
        return (s == ST_WRITE) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/bus_tristate_drv.sv
// Tri-state driver for the shared data bus; the only place the bus is driven
// from inside the controller.
module bus_tristate_drv #(
    parameter int WIDTH = 8
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0] bus
);

    assign bus = oe ? din : {WIDTH{1'bz}};

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding bus master for a shared-bus memory: IDLE -> WRITE|READ ->
// (RESP) -> TURN -> IDLE, with every memory-side pin decoded from registers.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    // Handshakes: a beat transfers on a rising edge where valid && ready;
    // valid is held by its source until then and ready never depends on valid.
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_re,
    output logic                 mem_we,
    inout  wire  [WIDTH-1:0]     data_bus,
    output logic                 busy,
    output state_t               dbg_state_o
);

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;
    logic                   bus_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The request direction is folded into the WRITE/READ choice, so only
    // address and store data need their own registers.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        bus_oe    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                mem_we  = 1'b1;
                bus_oe  = 1'b1;
                state_d = ST_TURN;
            end
            ST_READ: begin
                mem_re  = 1'b1;
                rdata_d = data_bus;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_addr    = addr_q;
    assign rsp_rdata   = rdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

    bus_tristate_drv #(
        .WIDTH (WIDTH)
    ) u_bus_drv (
        .oe  (bus_oe),
        .din (wdata_q),
        .bus (data_bus)
    );

    // Bus-safety invariants: exclusive enables, no contention, stable response.
    a_re_we_excl: assert property (@(posedge clk) disable iff (rst)
        !(mem_re && mem_we));

    a_no_contention: assert property (@(posedge clk) disable iff (rst)
        !(bus_oe && mem_re));

    a_drive_only_in_access: assert property (@(posedge clk) disable iff (rst)
        bus_oe |-> is_mem_access(state_q));

    a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata)));

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: a shared-bus memory model, a per-cycle bus-phase
// tracer, and scenario tasks checked against a reference memory and timeline.
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [7:0] C_W = "W";
  localparam logic [7:0] C_R = "R";
  localparam logic [7:0] C_P = "P";
  localparam logic [7:0] C_T = "T";
  localparam logic [7:0] C_I = "I";

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  wire  [DW-1:0] data_bus;
  logic          busy;
  state_t        dbg_state;

  logic [DW-1:0] mem_arr [16];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_q [$];
  logic          mem_init = 1'b1;
  int            n_vec = 0;
  int            n_err = 0;
  int            contend = 0;

  mem_bus_ctrl #(.ADDR_SIZE(AW), .WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .data_bus    (data_bus),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / memory environment ----------------
  always #5 clk = ~clk;

  assign data_bus = mem_re ? mem_arr[mem_addr] : {DW{BUS_IDLE_BIT}};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= 8'(i * 37 + 11);
    end else if (mem_we) begin
      mem_arr[mem_addr] <= data_bus;
    end
  end

  always @(negedge clk) begin
    if (!rst && dut.bus_oe && mem_re) contend <= contend + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cls();
    if (mem_we) return C_W;
    if (mem_re) return C_R;
    if (rsp_valid) return C_P;
    if (req_ready) return C_I;
    return C_T;
  endfunction

  // Expected bus-phase timeline after acceptance, straight from the protocol.
  function automatic logic [127:0] exp_trace(input bit wr, input int hold);
    logic [127:0] t;
    t = '0;
    if (wr) begin
      t = {t[119:0], C_W};
    end else begin
      t = {t[119:0], C_R};
      for (int i = 0; i <= hold; i++) t = {t[119:0], C_P};
    end
    t = {t[119:0], C_T};
    t = {t[119:0], C_I};
    return t;
  endfunction

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_wait: req_ready=%b after %0d cycles, required 1", req_ready, k);
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 4'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int hold, input bit junk,
                         output logic [127:0] trace, output logic [DW-1:0] bus_w,
                         output logic [AW-1:0] addr_seen, output logic [DW-1:0] rdata_seen,
                         output int unstable, output int drive_bad);
    int pc;
    logic [7:0] c;
    pc = 0;
    trace = '0;
    bus_w = '0;
    addr_seen = '0;
    rdata_seen = '0;
    unstable = 0;
    drive_bad = 0;
    issue(wr, a, d);
    for (int k = 0; k < 32; k++) begin
      c = cls();
      trace = {trace[119:0], c};
      if (c == C_W) begin
        bus_w = data_bus;
        addr_seen = mem_addr;
        if (dut.bus_oe !== 1'b1) drive_bad++;
      end else if (dut.bus_oe !== 1'b0) begin
        drive_bad++;
      end
      if (c == C_R) addr_seen = mem_addr;
      if (c == C_P) begin
        if (pc == 0) rdata_seen = rsp_rdata;
        else if (rsp_rdata !== rdata_seen) unstable++;
      end
      if (c == C_I) begin
        req_valid = 1'b0;
        break;
      end
      rsp_ready = (c == C_P) ? (pc >= hold) : 1'($urandom_range(0, 1));
      if (c == C_P) pc++;
      req_valid = junk;
      if (junk) begin
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 4'($urandom);
        req_wdata = 8'($urandom);
      end
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    n_vec++;
    if (rsp_rdata !== 8'h00) begin
      n_err++; $display("FAIL reset_rdata: got %h want 00", rsp_rdata);
    end
    #2 rst = 1'b0;
    step();
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    n_vec++;
    if ({mem_re, mem_we} !== 2'b00) begin
      n_err++; $display("FAIL reset_re_we: got %b want 00", {mem_re, mem_we});
    end
    n_vec++;
    if (mem_addr !== 4'h0) begin
      n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr);
    end
    n_vec++;
    if (dut.bus_oe !== 1'b0) begin
      n_err++; $display("FAIL reset_bus_drive: got %b want 0", dut.bus_oe);
    end
    n_vec++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL reset_rsp_busy: got %b want 00", {rsp_valid, busy});
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_store();
    logic [127:0] tr; logic [DW-1:0] bw, rd; logic [AW-1:0] as; int un, db;
    run_txn(1'b1, 4'h3, 8'hA5, 0, 1'b0, tr, bw, as, rd, un, db);
    ref_mem[3] = 8'hA5;
    n_vec++;
    if (tr !== exp_trace(1'b1, 0)) begin
      n_err++; $display("FAIL store_timeline: got %s want %s", tr, exp_trace(1'b1, 0));
    end
    n_vec++;
    if (bw !== 8'hA5 || as !== 4'h3) begin
      n_err++; $display("FAIL store_bus: got addr %h data %h want addr 3 data a5", as, bw);
    end
    n_vec++;
    if (mem_arr[3] !== ref_mem[3]) begin
      n_err++; $display("FAIL store_mem: got %h want %h", mem_arr[3], ref_mem[3]);
    end
    n_vec++;
    if (db != 0) begin
      n_err++; $display("FAIL store_drive: got %0d bad drive cycles want 0", db);
    end
    n_vec++;
    if (mem_addr !== 4'h3) begin
      n_err++; $display("FAIL store_addr_hold: got %h want 3", mem_addr);
    end
  endtask

  task automatic test_load();
    logic [127:0] tr; logic [DW-1:0] bw, rd; logic [AW-1:0] as; int un, db;
    run_txn(1'b0, 4'h3, 8'h00, 0, 1'b0, tr, bw, as, rd, un, db);
    n_vec++;
    if (tr !== exp_trace(1'b0, 0)) begin
      n_err++; $display("FAIL load_timeline: got %s want %s", tr, exp_trace(1'b0, 0));
    end
    n_vec++;
    if (rd !== ref_mem[3] || as !== 4'h3) begin
      n_err++; $display("FAIL load_data: got addr %h data %h want addr 3 data %h", as, rd, ref_mem[3]);
    end
    n_vec++;
    if (db != 0) begin
      n_err++; $display("FAIL load_drive: got %0d bad drive cycles want 0", db);
    end
  endtask

  task automatic test_load_stall();
    logic [127:0] tr; logic [DW-1:0] bw, rd; logic [AW-1:0] as, a; int un, db;
    a = 4'($urandom_range(4, 15));
    run_txn(1'b0, a, 8'h00, 5, 1'b1, tr, bw, as, rd, un, db);
    n_vec++;
    if (tr !== exp_trace(1'b0, 5)) begin
      n_err++; $display("FAIL stall_timeline: got %s want %s", tr, exp_trace(1'b0, 5));
    end
    n_vec++;
    if (rd !== ref_mem[a]) begin
      n_err++; $display("FAIL stall_data: got %h want %h", rd, ref_mem[a]);
    end
    n_vec++;
    if (un != 0) begin
      n_err++; $display("FAIL stall_stable: got %0d rdata changes want 0", un);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] tr; logic [DW-1:0] bw, rd; logic [AW-1:0] as; int un, db, c0;
    c0 = contend;
    run_txn(1'b1, 4'h2, 8'h5A, 0, 1'b1, tr, bw, as, rd, un, db);
    ref_mem[2] = 8'h5A;
    n_vec++;
    if (tr !== exp_trace(1'b1, 0) || bw !== 8'h5A) begin
      n_err++; $display("FAIL b2b_store1: got %s data %h want %s data 5a", tr, bw, exp_trace(1'b1, 0));
    end
    run_txn(1'b0, 4'h2, 8'h00, 0, 1'b1, tr, bw, as, rd, un, db);
    n_vec++;
    if (tr !== exp_trace(1'b0, 0) || rd !== ref_mem[2]) begin
      n_err++; $display("FAIL b2b_load: got %s data %h want %s data %h", tr, rd, exp_trace(1'b0, 0), ref_mem[2]);
    end
    run_txn(1'b1, 4'h2, 8'hFF, 0, 1'b1, tr, bw, as, rd, un, db);
    ref_mem[2] = 8'hFF;
    n_vec++;
    if (tr !== exp_trace(1'b1, 0) || mem_arr[2] !== ref_mem[2]) begin
      n_err++; $display("FAIL b2b_store2: got %s mem %h want %s mem ff", tr, mem_arr[2], exp_trace(1'b1, 0));
    end
    n_vec++;
    if (contend != c0) begin
      n_err++; $display("FAIL b2b_contention: got %0d contention cycles want 0", contend - c0);
    end
  endtask

  task automatic test_random();
    logic [127:0] tr; logic [DW-1:0] bw, rd, d, e; logic [AW-1:0] as, a; int un, db, hold;
    bit wr, junk;
    for (int n = 0; n < 24; n++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = 4'($urandom);
      d    = 8'($urandom);
      hold = $urandom_range(0, 3);
      junk = 1'($urandom_range(0, 1));
      if (!wr) exp_q.push_back(ref_mem[a]);
      run_txn(wr, a, d, hold, junk, tr, bw, as, rd, un, db);
      n_vec++;
      if (tr !== exp_trace(wr, hold) || as !== a || db != 0 || un != 0) begin
        n_err++;
        $display("FAIL rand_txn%0d: got %s addr %h drv %0d unst %0d want %s addr %h drv 0 unst 0",
                 n, tr, as, db, un, exp_trace(wr, hold), a);
      end
      if (wr) begin
        ref_mem[a] = d;
        n_vec++;
        if (bw !== d || mem_arr[a] !== ref_mem[a]) begin
          n_err++; $display("FAIL rand_store%0d: got bus %h mem %h want %h", n, bw, mem_arr[a], d);
        end
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if (rd !== e) begin
          n_err++; $display("FAIL rand_load%0d: got %h want %h", n, rd, e);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    // Store data equals current contents, so memory stays consistent either way.
    issue(1'b1, 4'h7, ref_mem[7]);
    n_vec++;
    if (mem_we !== 1'b1 || dut.bus_oe !== 1'b1) begin
      n_err++; $display("FAIL arst_pre_write: got we %b drive %b want 1 1", mem_we, dut.bus_oe);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({mem_we, dut.bus_oe, busy} !== 3'b000 || mem_addr !== 4'h0) begin
      n_err++; $display("FAIL arst_write_drop: got we/drive/busy %b addr %h want 000 addr 0",
                        {mem_we, dut.bus_oe, busy}, mem_addr);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    n_vec++;
    if (dbg_state !== ST_IDLE || req_ready !== 1'b1) begin
      n_err++; $display("FAIL arst_write_idle: got state %0d ready %b want %0d 1", dbg_state, req_ready, ST_IDLE);
    end
    rsp_ready = 1'b0;
    issue(1'b0, 4'h5, 8'h00);
    step();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[5]) begin
      n_err++; $display("FAIL arst_pre_resp: got valid %b data %h want 1 %h", rsp_valid, rsp_rdata, ref_mem[5]);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
      n_err++; $display("FAIL arst_resp_drop: got valid %b data %h want 0 00", rsp_valid, rsp_rdata);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    n_vec++;
    if (dbg_state !== ST_IDLE || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL arst_resp_idle: got state %0d valid %b want %0d 0", dbg_state, rsp_valid, ST_IDLE);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_store();
    test_load();
    test_load_stall();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Bus master sitting directly upstream of the shared-bus memory. It accepts single load/store requests from the core over a valid/ready handshake and sequences them onto the memory's addr/re/we lines and the bidirectional data bus. It returns read data over a valid/ready response channel and inserts turnaround cycles so the bus never has two drivers.

Parameters:
ADDR_SIZE, 4, memory address width in bits
WIDTH, 8, data word width in bits

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  core request present
req_ready  output  1  controller can accept a request this cycle
req_write  input  1  1 = store, 0 = load; sampled with req_valid & req_ready
req_addr  input  ADDR_SIZE  request address
req_wdata  input  WIDTH  store data
rsp_valid  output  1  load data available
rsp_ready  input  1  core accepts load data
rsp_rdata  output  WIDTH  load data; valid only while rsp_valid=1
mem_addr  output  ADDR_SIZE  memory address
mem_re  output  1  memory read enable; memory drives data_bus while high
mem_we  output  1  memory write enable
data_bus  inout  WIDTH  shared data bus; controller drives it only in WRITE
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, WRITE, READ, RESP, TURN. Encoding is held in a state register.
- mem_re, mem_we, mem_addr and the bus drive enable are decoded from the state register and latched request registers only. There is no combinational path from req_* to any mem_* pin.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_addr, req_write and req_wdata.
  - Go to WRITE if req_write=1, else READ.
- WRITE (exactly 1 cycle):
  - mem_we=1, mem_re=0, mem_addr=latched addr.
  - data_bus driven with latched wdata.
  - The memory samples at the closing edge.
  - Next state is TURN.
- READ (exactly 1 cycle):
  - mem_re=1, mem_we=0, data_bus released to Z.
  - data_bus is captured into the rdata register at the closing edge.
  - Next state is RESP.
- RESP:
  - rsp_valid=1, rsp_rdata=rdata register, mem_re=0.
  - Stay in RESP while rsp_ready=0.
  - On rsp_ready=1, go to TURN.
- TURN (exactly 1 cycle):
  - re=0, we=0, bus Z. This guarantees at least one undriven cycle between the memory's drive and the controller's drive.
  - Next state is IDLE.
- Latency:
  - Store: accepted at edge N, we high in cycle N+1, req_ready high again in cycle N+3.
  - Load: accepted at edge N, re high in cycle N+1, rsp_valid from cycle N+2.
  - At most one outstanding request.
- Stores produce no response. Store completion is indicated by the return to IDLE.
- req_valid outside IDLE is ignored (req_ready=0). Request inputs need not stay stable after acceptance.
- mem_addr holds the latched address in every state, including IDLE after a transaction.
- Captured read data is taken as-is (X/Z propagate); no checking is done.
- Reset (asynchronous, any state):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, mem_re=0, mem_we=0, mem_addr=0, busy=0.
  - The drive enable deasserts immediately, so data_bus goes to Z without waiting for a clock.
  - Reset mid-load drops the response. Reset mid-store gives no completion guarantee.
- Invariants:
  - Never mem_re & mem_we.
  - Never controller drive & mem_re.
  - rsp_valid holds with stable rsp_rdata until accepted.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding localparams (IDLE=0, WRITE=1, READ=2, RESP=3, TURN=4, 3-bit);
  - bus-idle value used by benches.
- One natural sub-module: bus_tristate_drv (params WIDTH; ports oe, din, bus inout). It isolates the only tri-state assignment so lint/synthesis of bidirectional pads stays in one place. All other logic lives in the top module.

Test Plan:
- Reset then idle -> req_ready=1, mem_re=mem_we=0, mem_addr=0, data_bus=Z; rsp_valid=0.
- Store addr=4'h3 data=8'hA5 -> one cycle with mem_we=1, mem_addr=3, data_bus=A5, then TURN; req_ready returns on the third cycle after acceptance; memory model holds A5 at address 3.
- Load addr=4'h3 after the above, with rsp_ready=1 -> mem_re high for exactly 1 cycle; rsp_valid next cycle with rsp_rdata=8'hA5.
- Load with rsp_ready held 0 for 5 cycles -> rsp_valid stays 1 and rsp_rdata stays stable; req_valid pulses during that time are not accepted; completes when rsp_ready=1.
- Back-to-back store(2,8'h5A), load(2), store(2,8'hFF) with req_valid always high -> sequence completes with rdata=5A; bus monitor sees no cycle where the controller drives while mem_re=1; a TURN cycle is present between each pair.
- Async rst asserted mid-WRITE and mid-RESP (between clock edges) -> data_bus goes Z and mem_we/rsp_valid drop within the same cycle; state is IDLE after rst release.
